// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the ARMAria core.
// Strobes decode from the state register; completion strobes qualify with mem_ready or a button press.
module control_sequencer #(
    parameter int ID_WIDTH    = 7,
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ID_WIDTH-1:0]    ID,
    input  logic                   condition_met,
    input  logic                   mem_ready,
    input  logic                   enter_button,
    output logic                   ir_load,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   addr_sel,
    output logic                   reg_write,
    output logic                   out_strobe,
    output logic                   halted,
    output logic                   waiting,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [ID_WIDTH-1:0] ID_BRANCH_A   = ID_WIDTH'('h26);
    localparam logic [ID_WIDTH-1:0] ID_MEM_LO     = ID_WIDTH'('h28);
    localparam logic [ID_WIDTH-1:0] ID_MEM_HI     = ID_WIDTH'('h37);
    localparam logic [ID_WIDTH-1:0] ID_ST_0       = ID_WIDTH'('h28);
    localparam logic [ID_WIDTH-1:0] ID_ST_1       = ID_WIDTH'('h29);
    localparam logic [ID_WIDTH-1:0] ID_ST_2       = ID_WIDTH'('h2A);
    localparam logic [ID_WIDTH-1:0] ID_ST_3       = ID_WIDTH'('h30);
    localparam logic [ID_WIDTH-1:0] ID_ST_4       = ID_WIDTH'('h32);
    localparam logic [ID_WIDTH-1:0] ID_ST_5       = ID_WIDTH'('h34);
    localparam logic [ID_WIDTH-1:0] ID_ST_6       = ID_WIDTH'('h36);
    localparam logic [ID_WIDTH-1:0] ID_OUTPUT     = ID_WIDTH'('h45);
    localparam logic [ID_WIDTH-1:0] ID_PAUSE      = ID_WIDTH'('h46);
    localparam logic [ID_WIDTH-1:0] ID_INPUT      = ID_WIDTH'('h47);
    localparam logic [ID_WIDTH-1:0] ID_SWI        = ID_WIDTH'('h48);
    localparam logic [ID_WIDTH-1:0] ID_BRANCH_B   = ID_WIDTH'('h49);
    localparam logic [ID_WIDTH-1:0] ID_NOP        = ID_WIDTH'('h4A);
    localparam logic [ID_WIDTH-1:0] ID_HLT        = ID_WIDTH'('h4B);
    localparam logic [ID_WIDTH-1:0] ID_BRANCH_C   = ID_WIDTH'('h4C);
    localparam logic [ID_WIDTH-1:0] ID_RESET      = ID_WIDTH'('h64);
    localparam logic [ID_WIDTH-1:0] ID_INVALID_LO = ID_WIDTH'('h7A);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXECUTE    = 4'd4,
        S_MEM        = 4'd5,
        S_WRITEBACK  = 4'd6,
        S_WAIT_BTN   = 4'd7,
        S_HALT       = 4'd8,
        S_ERROR      = 4'd9
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   btn_meta_q, btn_meta_d;
    logic                   btn_sync_q, btn_sync_d;
    logic                   btn_prev_q, btn_prev_d;
    logic                   press;
    logic                   timeout_hit;
    logic                   retire;

    function automatic logic is_branch(input logic [ID_WIDTH-1:0] id);
        return (id == ID_BRANCH_A) || (id == ID_SWI) ||
               (id == ID_BRANCH_B) || (id == ID_BRANCH_C);
    endfunction

    function automatic logic is_mem(input logic [ID_WIDTH-1:0] id);
        return (id >= ID_MEM_LO) && (id <= ID_MEM_HI);
    endfunction

    function automatic logic is_store(input logic [ID_WIDTH-1:0] id);
        return (id == ID_ST_0) || (id == ID_ST_1) || (id == ID_ST_2) ||
               (id == ID_ST_3) || (id == ID_ST_4) || (id == ID_ST_5) ||
               (id == ID_ST_6);
    endfunction

    // Third flop only remembers the previous synchronized level for edge detection.
    assign press       = btn_sync_q & ~btn_prev_q;
    assign timeout_hit = (wait_cnt_q == WAIT_LAST);

    always_comb begin
        btn_meta_d = enter_button;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        wait_cnt_d = wait_cnt_q;
        retire     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        reg_write  = 1'b0;
        out_strobe = 1'b0;
        halted     = 1'b0;
        waiting    = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req    = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_FETCH_WAIT;
            end

            S_FETCH_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                id_d = ID;
                if (ID == ID_HLT) begin
                    state_d = S_HALT;
                end else if (ID == ID_RESET) begin
                    state_d = S_RESET;
                end else if (ID >= ID_INVALID_LO) begin
                    state_d = S_ERROR;
                end else if (ID == ID_NOP) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if ((ID == ID_PAUSE) || (ID == ID_INPUT)) begin
                    state_d = S_WAIT_BTN;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (is_branch(id_q)) begin
                    // Branch target load tracks the flag unit within the cycle.
                    pc_load   = condition_met;
                    reg_write = (id_q == ID_SWI);
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end else if (id_q == ID_OUTPUT) begin
                    out_strobe = 1'b1;
                    state_d    = S_FETCH;
                    retire     = 1'b1;
                end else if (is_mem(id_q)) begin
                    wait_cnt_d = '0;
                    state_d    = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store(id_q);
                if (mem_ready) begin
                    if (is_store(id_q)) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_WRITEBACK: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end

            S_WAIT_BTN: begin
                waiting = 1'b1;
                if (press) begin
                    reg_write = (id_q == ID_INPUT);
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
            end

            S_HALT, S_ERROR: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_ERROR;
            end
        endcase

        retired_d = retire ? (retired_q + COUNT_WIDTH'(1)) : retired_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET;
            id_q       <= '0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: hand-computed instruction table, hand sequences, then random
// instructions checked against an instruction-level model of cycle counts and strobe totals.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  id_in = '0;
    logic        condition_met = 1'b0;
    logic        mem_ready = 1'b0;
    logic        enter_button = 1'b0;
    logic        ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel;
    logic        reg_write, out_strobe, halted, waiting;
    logic [3:0]  state;
    logic [15:0] retired;

    always #5 clock = ~clock;

    control_sequencer #(.ID_WIDTH(7), .MEM_TIMEOUT(15), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .ID(id_in), .condition_met(condition_met),
        .mem_ready(mem_ready), .enter_button(enter_button), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .reg_write(reg_write), .out_strobe(out_strobe),
        .halted(halted), .waiting(waiting), .state(state), .retired(retired)
    );

    // fin: 0 = back to FETCH, 1 = HALT, 2 = ERROR, 3 = RESET state
    typedef struct {
        logic [6:0] id;
        int lf; int lm; int w; bit cond;
        int cyc; int req; int we; int irl; int inc; int regw; int pcl; int outs; int wt; int ret; int fin;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ret = '0;
    vec_t        tbl[$];
    vec_t        v, e, m;
    logic [3:0]  exp_seq [8];
    logic [6:0]  br_ids [4]  = '{7'h26, 7'h48, 7'h49, 7'h4C};
    logic [6:0]  sp_ids [6]  = '{7'h4A, 7'h46, 7'h47, 7'h45, 7'h64, 7'h4B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] id, input int lf, input int lm, input int w,
                                input bit cond, input int cyc, input int req, input int we,
                                input int irl, input int regw, input int pcl, input int outs,
                                input int wt, input int ret, input int fin);
        vec_t r;
        r.id = id; r.lf = lf; r.lm = lm; r.w = w; r.cond = cond;
        r.cyc = cyc; r.req = req; r.we = we; r.irl = irl; r.inc = irl; r.regw = regw;
        r.pcl = pcl; r.outs = outs; r.wt = wt; r.ret = ret; r.fin = fin;
        return r;
    endfunction

    // Instruction-level reference: each phase contributes its cycle count and strobes.
    function automatic vec_t model(input vec_t s);
        vec_t r = s;
        int   ml;
        bit   store;
        r.cyc = 0; r.req = 0; r.we = 0; r.irl = 0; r.inc = 0; r.regw = 0;
        r.pcl = 0; r.outs = 0; r.wt = 0; r.ret = 0; r.fin = 0;
        r.req = 1 + ((s.lf <= 15) ? s.lf : 15);
        r.cyc = r.req;
        if (s.lf > 15) begin
            r.fin = 2;
            return r;
        end
        r.irl = 1; r.inc = 1;
        r.cyc += 1;
        if (s.id == 7'h4B) r.fin = 1;
        else if (s.id == 7'h64) r.fin = 3;
        else if (s.id >= 7'h7A) r.fin = 2;
        else if (s.id == 7'h4A) r.ret = 1;
        else if (s.id == 7'h46 || s.id == 7'h47) begin
            r.wt   = s.w + 3;
            r.cyc += r.wt;
            r.regw = (s.id == 7'h47) ? 1 : 0;
            r.ret  = 1;
        end else begin
            r.cyc += 1;
            if (s.id inside {7'h26, 7'h48, 7'h49, 7'h4C}) begin
                r.pcl  = s.cond ? 1 : 0;
                r.regw = (s.id == 7'h48) ? 1 : 0;
                r.ret  = 1;
            end else if (s.id == 7'h45) begin
                r.outs = 1;
                r.ret  = 1;
            end else if (s.id inside {[7'h28:7'h37]}) begin
                store  = s.id inside {7'h28, 7'h29, 7'h2A, 7'h30, 7'h32, 7'h34, 7'h36};
                ml     = (s.lm <= 15) ? s.lm : 15;
                r.cyc += ml;
                r.req += ml;
                if (store) r.we = ml;
                if (s.lm > 15) r.fin = 2;
                else if (store) r.ret = 1;
                else begin
                    r.cyc += 1; r.regw = 1; r.ret = 1;
                end
            end else begin
                r.cyc += 1; r.regw = 1; r.ret = 1;
            end
        end
        return r;
    endfunction

    // Called on a falling edge; returns on the falling edge where the instruction has ended.
    task automatic run_instr(input vec_t s, output vec_t r);
        int fw_n, m_n, b_n, guard;
        logic [3:0] st;
        r = s;
        r.cyc = 0; r.req = 0; r.we = 0; r.irl = 0; r.inc = 0; r.regw = 0;
        r.pcl = 0; r.outs = 0; r.wt = 0; r.ret = 0; r.fin = -1;
        guard = 0;
        while (state !== 4'd1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (state !== 4'd1) begin
            r.fin = -2;
            return;
        end
        id_in = s.id; condition_met = s.cond; enter_button = 1'b0; mem_ready = 1'b0;
        fw_n = 0; m_n = 0; b_n = 0;
        for (int k = 0; k < 200; k++) begin
            st = state;
            if (k > 0 && (st == 4'd1 || st == 4'd0 || st == 4'd8 || st == 4'd9)) begin
                r.fin = (st == 4'd1) ? 0 : (st == 4'd8) ? 1 : (st == 4'd9) ? 2 : 3;
                break;
            end
            mem_ready = 1'b0;
            if (st == 4'd2) begin mem_ready = (fw_n + 1 == s.lf); fw_n++; end
            if (st == 4'd5) begin mem_ready = (m_n + 1 == s.lm); m_n++; end
            if (st == 4'd7) begin if (b_n == s.w) enter_button = 1'b1; b_n++; end
            #1;
            r.cyc++;
            r.req  += int'(mem_req);
            r.we   += int'(mem_we);
            r.irl  += int'(ir_load);
            r.inc  += int'(pc_inc);
            r.regw += int'(reg_write);
            r.pcl  += int'(pc_load);
            r.outs += int'(out_strobe);
            r.wt   += int'(waiting);
            @(negedge clock);
        end
        mem_ready = 1'b0;
    endtask

    task automatic do_reset(input string p);
        #2 reset = 1'b0;
        #1;
        check({p, "_rst_strobes"}, {ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel,
                                    reg_write, out_strobe, halted, waiting}, 0);
        check({p, "_rst_state"}, state, 0);
        check({p, "_rst_retired"}, retired, 0);
        exp_ret = '0;
        enter_button = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic compare(input string p, input vec_t x, input vec_t y);
        check({p, "_end"},        y.fin,  x.fin);
        check({p, "_cycles"},     y.cyc,  x.cyc);
        check({p, "_mem_req"},    y.req,  x.req);
        check({p, "_mem_we"},     y.we,   x.we);
        check({p, "_ir_load"},    y.irl,  x.irl);
        check({p, "_pc_inc"},     y.inc,  x.irl);
        check({p, "_reg_write"},  y.regw, x.regw);
        check({p, "_pc_load"},    y.pcl,  x.pcl);
        check({p, "_out_strobe"}, y.outs, x.outs);
        check({p, "_waiting"},    y.wt,   x.wt);
    endtask

    task automatic post(input string p, input vec_t x, input vec_t y);
        logic [3:0] st0;
        if (y.fin == 0 || y.fin == 3) begin
            exp_ret = exp_ret + 16'(x.ret);
            check({p, "_retired"}, retired, exp_ret);
        end else begin
            if (y.fin == 1 || y.fin == 2) begin
                st0 = state;
                for (int k = 0; k < 3; k++) begin
                    mem_ready = 1'b1;
                    @(negedge clock);
                    check({p, "_stuck_halted"}, halted, 1);
                    check({p, "_stuck_no_req"}, mem_req, 0);
                    check({p, "_stuck_state"}, state, st0);
                end
                mem_ready = 1'b0;
            end
            do_reset(p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int fwc, regw_n, r;
        exp_seq = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd6, 4'd1};

        repeat (3) @(negedge clock);
        check("reset_strobes", {ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel,
                                reg_write, out_strobe, halted, waiting}, 0);
        check("reset_state", state, 0);
        check("reset_retired", retired, 0);

        // ALU op right after reset release, fetch completes on the second wait cycle
        reset = 1'b1;
        id_in = 7'h04;
        fwc = 0; regw_n = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("alu_seq%0d", k), state, exp_seq[k]);
            mem_ready = (state == 4'd2 && fwc == 1);
            if (state == 4'd2) fwc++;
            #1 regw_n += int'(reg_write);
            if (k < 7) @(negedge clock);
        end
        mem_ready = 1'b0;
        check("alu_reg_write_pulses", regw_n, 1);
        check("alu_retired", retired, 1);
        exp_ret = 16'd1;

        //           id     lf  lm  w  c   cyc req we irl rw pl os wt rt fin
        tbl.push_back(mk(7'h04,  2, 1, 0, 0,  6,  3, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h31,  1, 3, 0, 0,  8,  5, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h30,  1, 2, 0, 0,  6,  4, 2, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h49,  1, 1, 0, 1,  4,  2, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(7'h49,  1, 1, 0, 0,  4,  2, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h48,  1, 1, 0, 1,  4,  2, 0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(7'h45,  3, 1, 0, 0,  6,  4, 0, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(7'h4A,  1, 1, 0, 0,  3,  2, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h46,  1, 1, 20, 0, 26, 2, 0, 1, 0, 0, 0, 23, 1, 0));
        tbl.push_back(mk(7'h47,  1, 1, 0, 0,  6,  2, 0, 1, 1, 0, 0, 3, 1, 0));
        tbl.push_back(mk(7'h26,  1, 1, 0, 1,  4,  2, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(7'h64,  1, 1, 0, 0,  3,  2, 0, 1, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(7'h4B,  1, 1, 0, 0,  3,  2, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(7'h7C,  1, 1, 0, 0,  3,  2, 0, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(7'h7A,  1, 1, 0, 0,  3,  2, 0, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(7'h04, 16, 1, 0, 0, 16, 16, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(7'h31,  1, 16, 0, 0, 19, 17, 0, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(7'h36,  1, 16, 0, 0, 19, 17, 15, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(7'h28,  1, 1, 0, 0,  5,  3, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h37,  1, 1, 0, 0,  6,  3, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h38,  1, 1, 0, 0,  5,  2, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h79,  1, 1, 0, 0,  5,  2, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h29,  1, 4, 0, 0,  8,  6, 4, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7'h04, 15, 1, 0, 0, 19, 16, 0, 1, 1, 0, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            run_instr(tbl[i], m);
            compare($sformatf("vec%0d", i), tbl[i], m);
            post($sformatf("vec%0d", i), tbl[i], m);
        end

        // Reset pulse while a load sits in MEM with mem_req high
        id_in = 7'h31;
        for (int k = 0; k < 60 && state !== 4'd5; k++) begin
            mem_ready = (state == 4'd2);
            @(negedge clock);
        end
        mem_ready = 1'b0;
        check("mid_in_mem", state, 5);
        check("mid_req_addr", {mem_req, addr_sel}, 2'b11);
        check("mid_retired_before", retired, exp_ret);
        do_reset("mid");
        check("mid_restart_reset", state, 0);
        @(negedge clock);
        check("mid_restart_fetch", state, 1);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) v.id = 7'($urandom_range(8'h28, 8'h37));
            else if (r == 3) v.id = br_ids[$urandom_range(0, 3)];
            else if (r == 4) v.id = sp_ids[$urandom_range(0, 5)];
            else if (r == 5 && $urandom_range(0, 3) == 0) v.id = 7'($urandom_range(8'h7A, 8'h7F));
            else v.id = 7'($urandom_range(0, 127));
            v.lf   = ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(1, 15);
            v.lm   = ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(1, 15);
            v.w    = $urandom_range(0, 4);
            v.cond = 1'($urandom_range(0, 1));
            e = model(v);
            run_instr(e, m);
            compare($sformatf("rnd%0d_id%02h", n, v.id), e, m);
            post($sformatf("rnd%0d", n), e, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
